// File: rtl/pg_port_tx_gate.sv
// AFU port TX gate: one-stage AXI-S output register that closes packets cut by a port reset.
// Optional statistics counters (pkt_cnt, trunc_cnt) are built in with `define PG_PORT_TX_GATE_STATS_EN.
module pg_port_tx_gate #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int POISON_BIT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     port_rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic                     m_tlast
`ifdef PG_PORT_TX_GATE_STATS_EN
  ,
  output logic [31:0]              pkt_cnt,
  output logic [15:0]              trunc_cnt
`endif
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam logic [TUSER_WIDTH-1:0] POISON_USER = TUSER_WIDTH'(1) << POISON_BIT;

  typedef enum logic [1:0] {RUN_IDLE, RUN_PKT, TRUNC, BLOCK} state_t;

  state_t                   state_reg;
  logic                     m_tvalid_reg;
  logic                     m_tlast_reg;
  logic [TDATA_WIDTH-1:0]   m_tdata_reg;
  logic [KEEP_WIDTH-1:0]    m_tkeep_reg;
  logic [TUSER_WIDTH-1:0]   m_tuser_reg;

  logic out_free;
  logic s_ready;
  logic accept;
  logic term_load;
  logic load;

  // Output slot can take a new beat when empty or when its current beat leaves this cycle.
  assign out_free = !m_tvalid_reg || m_tready;

  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      case (state_reg)
        RUN_IDLE, RUN_PKT: s_ready = port_rst_n && out_free;
        BLOCK:             s_ready = 1'b1;
        default:           s_ready = 1'b0;
      endcase
    end
  end

  assign accept    = s_tvalid && s_ready &&
                     ((state_reg == RUN_IDLE) || (state_reg == RUN_PKT));
  assign term_load = (state_reg == TRUNC) && out_free;
  assign load      = accept || term_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN_IDLE;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
    end else begin
      if (load) begin
        m_tvalid_reg <= 1'b1;
        m_tlast_reg  <= term_load ? 1'b1 : s_tlast;
      end else if (m_tready) begin
        m_tvalid_reg <= 1'b0;
      end
      case (state_reg)
        RUN_IDLE: begin
          if (!port_rst_n)             state_reg <= BLOCK;
          else if (accept && !s_tlast) state_reg <= RUN_PKT;
        end
        RUN_PKT: begin
          // A port reset mid-packet always owes the sink a terminating beat.
          if (!port_rst_n)            state_reg <= TRUNC;
          else if (accept && s_tlast) state_reg <= RUN_IDLE;
        end
        TRUNC: begin
          if (term_load) state_reg <= BLOCK;
        end
        BLOCK: begin
          if (port_rst_n) state_reg <= RUN_IDLE;
        end
        default: state_reg <= RUN_IDLE;
      endcase
    end
  end

  // Payload is meaningless while m_tvalid is low, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      if (term_load) begin
        m_tdata_reg <= '0;
        m_tkeep_reg <= '0;
        m_tuser_reg <= POISON_USER;
      end else begin
        m_tdata_reg <= s_tdata;
        m_tkeep_reg <= s_tkeep;
        m_tuser_reg <= s_tuser;
      end
    end
  end

  assign s_tready = s_ready;
  assign m_tvalid = m_tvalid_reg;
  assign m_tlast  = m_tlast_reg;
  assign m_tdata  = m_tdata_reg;
  assign m_tkeep  = m_tkeep_reg;
  assign m_tuser  = m_tuser_reg;

`ifdef PG_PORT_TX_GATE_STATS_EN
  logic [31:0] pkt_cnt_reg;
  logic [15:0] trunc_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg   <= '0;
      trunc_cnt_reg <= '0;
    end else begin
      if (m_tvalid_reg && m_tready && m_tlast_reg) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      if (term_load && (trunc_cnt_reg != 16'hFFFF)) trunc_cnt_reg <= trunc_cnt_reg + 16'd1;
    end
  end

  assign pkt_cnt   = pkt_cnt_reg;
  assign trunc_cnt = trunc_cnt_reg;
`endif

endmodule

// File: tb/tb_pg_port_tx_gate.sv
// Self-checking bench for pg_port_tx_gate: directed port-reset scenarios plus a random
// traffic run scored against a one-slot queue model of the output register.
module tb_pg_port_tx_gate;

  localparam int TDW = 64;
  localparam int TUW = 10;
  localparam int PB  = 0;
  localparam int KW  = TDW / 8;
  localparam logic [TUW-1:0] POISON = TUW'(1) << PB;

  typedef struct packed {
    logic [TDW-1:0] d;
    logic [KW-1:0]  k;
    logic [TUW-1:0] u;
    logic           l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           port_rst_n = 1'b1;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [TDW-1:0] s_tdata = '0;
  logic [KW-1:0]  s_tkeep = '0;
  logic [TUW-1:0] s_tuser = '0;
  logic           s_tlast = 1'b0;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic [TDW-1:0] m_tdata;
  logic [KW-1:0]  m_tkeep;
  logic [TUW-1:0] m_tuser;
  logic           m_tlast;
`ifdef PG_PORT_TX_GATE_STATS_EN
  logic [31:0]    pkt_cnt;
  logic [15:0]    trunc_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_trunc = 0;

  always #5 clk = ~clk;

  pg_port_tx_gate #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .POISON_BIT(PB)) dut (
    .clk(clk), .rst_n(rst_n), .port_rst_n(port_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tuser(m_tuser), .m_tlast(m_tlast)
`ifdef PG_PORT_TX_GATE_STATS_EN
    , .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
`endif
  );

  // One clock cycle: inputs change 1ns after the rising edge, outputs are sampled at the falling edge.
  task automatic drive(input logic v, input logic [TDW-1:0] d, input logic [KW-1:0] k,
                       input logic [TUW-1:0] u, input logic l, input logic mr, input logic pr);
    @(posedge clk);
    #1;
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l;
    m_tready = mr; port_rst_n = pr;
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
`ifdef PG_PORT_TX_GATE_STATS_EN
    checks++;
    if (pkt_cnt !== 32'(exp_pkt)) begin
      errors++; $display("FAIL %s pkt_cnt: got %0d expected %0d", tag, pkt_cnt, exp_pkt);
    end
    checks++;
    if (trunc_cnt !== 16'(exp_trunc)) begin
      errors++; $display("FAIL %s trunc_cnt: got %0d expected %0d", tag, trunc_cnt, exp_trunc);
    end
`else
    $display("%s: counters not built", tag);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b1; s_tvalid = 1'b1; port_rst_n = 1'b1; m_tready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset m_tlast: got %b expected 0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset s_tready: got %b expected 0", s_tready); end
    check_counters("reset");
    @(posedge clk); #1; rst_n = 1'b1; s_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release s_tready: got %b expected 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_release m_tvalid: got %b expected 0", m_tvalid); end
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    beat_t b [3];
    for (int i = 0; i < 3; i++) begin
      b[i].d = {$urandom, $urandom}; b[i].k = KW'($urandom); b[i].u = TUW'($urandom); b[i].l = (i == 2);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, b[i].d, b[i].k, b[i].u, b[i].l, 1'b1, 1'b1);
      else       drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
      if (i < 3) begin
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL pt_s_tready c%0d: got %b expected 1", i, s_tready); end
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast} !== {1'b1, b[i-1]}) begin
          errors++; $display("FAIL pt_beat%0d: got v=%b d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                             i-1, m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast, b[i-1].d, b[i-1].k, b[i-1].u, b[i-1].l);
        end else $display("passthrough beat %0d data=%h last=%b", i-1, m_tdata, m_tlast);
      end
      if (i == 4) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL pt_idle m_tvalid: got %b expected 0", m_tvalid); end
      end
    end
    exp_pkt++;
    check_counters("passthrough");
  endtask

  task automatic test_backpressure();
    beat_t b [4];
    int idx = 0;
    int out_idx = 0;
    logic mr;
    for (int i = 0; i < 4; i++) begin
      b[i].d = {$urandom, $urandom}; b[i].k = KW'($urandom); b[i].u = TUW'($urandom); b[i].l = (i == 3);
    end
    for (int c = 0; c < 15; c++) begin
      mr = !(c >= 2 && c < 7);
      if (idx < 4) drive(1'b1, b[idx].d, b[idx].k, b[idx].u, b[idx].l, mr, 1'b1);
      else         drive(1'b0, '0, '0, '0, 1'b0, mr, 1'b1);
      if (c >= 2 && c < 7) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== b[1].d || m_tuser !== b[1].u || s_tready !== 1'b0) begin
          errors++; $display("FAIL bp_hold c%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0", c, m_tvalid, m_tdata, s_tready, b[1].d);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (out_idx >= 4) begin
          errors++; $display("FAIL bp_extra_beat: got beat %0d expected only 4", out_idx);
        end else if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== b[out_idx]) begin
          errors++; $display("FAIL bp_beat%0d: got d=%h l=%b expected d=%h l=%b", out_idx, m_tdata, m_tlast, b[out_idx].d, b[out_idx].l);
        end else $display("backpressure beat %0d data=%h last=%b", out_idx, m_tdata, m_tlast);
        out_idx++;
      end
      if (s_tvalid && s_tready) idx++;
    end
    checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", idx); end
    checks++; if (out_idx !== 4) begin errors++; $display("FAIL bp_emitted: got %0d expected 4", out_idx); end
    exp_pkt++;
    check_counters("backpressure");
  endtask

  task automatic test_trunc();
    logic [TDW-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom};
    drive(1'b1, d[0], '1, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, d[1], '1, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tdata !== d[0] || m_tvalid !== 1'b1) begin errors++; $display("FAIL tr_beat0: got v=%b d=%h expected d=%h", m_tvalid, m_tdata, d[0]); end
    drive(1'b1, d[2], '1, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL tr_cut_ready: got %b expected 0", s_tready); end
    checks++; if (m_tdata !== d[1] || m_tvalid !== 1'b1 || m_tlast !== 1'b0) begin errors++; $display("FAIL tr_beat1: got v=%b d=%h expected d=%h", m_tvalid, m_tdata, d[1]); end
    drive(1'b1, d[2], '1, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL tr_gap: got rdy=%b v=%b expected 0 0", s_tready, m_tvalid); end
    drive(1'b1, d[2], '1, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast} !== {1'b1, {TDW{1'b0}}, {KW{1'b0}}, POISON, 1'b1}) begin
      errors++; $display("FAIL tr_term: got v=%b d=%h k=%h u=%h l=%b expected v=1 d=0 k=0 u=%h l=1", m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast, POISON);
    end else $display("truncation beat tuser=%h", m_tuser);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL tr_block_ready: got %b expected 1", s_tready); end
    drive(1'b1, d[3], '1, '0, 1'b1, 1'b1, 1'b0);
    checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL tr_discard: got rdy=%b v=%b expected 1 0", s_tready, m_tvalid); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, d[4], '1, '0, 1'b1, 1'b1, 1'b1);
    checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL tr_restart: got rdy=%b v=%b expected 1 0", s_tready, m_tvalid); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== d[4] || m_tlast !== 1'b1) begin errors++; $display("FAIL tr_next_pkt: got v=%b d=%h l=%b expected d=%h l=1", m_tvalid, m_tdata, m_tlast, d[4]); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL tr_tail: got v=%b expected 0", m_tvalid); end
    exp_pkt += 2; exp_trunc++;
    check_counters("trunc");
  endtask

  task automatic test_trunc_stall();
    logic [TDW-1:0] d0, d1;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
    drive(1'b1, d0, '1, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, d1, '1, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL ts_cut_ready: got %b expected 0", s_tready); end
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(1'b1, d1, '1, '0, 1'b0, 1'b0, c == 0 ? 1'b0 : 1'b1);
      else       drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== d0 || m_tlast !== 1'b0) begin
        errors++; $display("FAIL ts_hold c%0d: got v=%b d=%h l=%b expected v=1 d=%h l=0", c, m_tvalid, m_tdata, m_tlast, d0);
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast} !== {1'b1, {TDW{1'b0}}, {KW{1'b0}}, POISON, 1'b1}) begin
      errors++; $display("FAIL ts_term: got v=%b d=%h k=%h u=%h l=%b expected terminating beat", m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast);
    end else $display("stalled truncation beat tuser=%h", m_tuser);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tkeep !== '0) begin errors++; $display("FAIL ts_term_hold: got v=%b l=%b k=%h expected 1 1 0", m_tvalid, m_tlast, m_tkeep); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL ts_idle: got v=%b rdy=%b expected 0 1", m_tvalid, s_tready); end
    exp_pkt++; exp_trunc++;
    check_counters("trunc_stall");
  endtask

  task automatic test_block_idle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {$urandom, $urandom}, KW'($urandom), TUW'($urandom), 1'($urandom), 1'b1, 1'b0);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bi_valid c%0d: got %b expected 0", i, m_tvalid); end
      checks++;
      if (s_tready !== (i != 0)) begin errors++; $display("FAIL bi_ready c%0d: got %b expected %b", i, s_tready, i != 0); end
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL bi_release: got v=%b rdy=%b expected 0 1", m_tvalid, s_tready); end
    $display("block_idle: 10 beats dropped");
    check_counters("block_idle");
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic v, mr;
    int nout = 0;
    for (int c = 0; c < 600; c++) begin
      b.d = {$urandom, $urandom}; b.k = KW'($urandom); b.u = TUW'($urandom);
      b.l = ($urandom_range(0, 3) == 0);
      v  = (c < 590) ? ($urandom_range(0, 2) != 0) : 1'b0;
      mr = (c < 590) ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(v, b.d, b.k, b.u, b.l, mr, 1'b1);
      checks++;
      if (m_tvalid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, m_tvalid, q.size() != 0); end
      checks++;
      if (s_tready !== (q.size() == 0 || mr)) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, s_tready, q.size() == 0 || mr); end
      if (m_tvalid && q.size() != 0) begin
        checks++;
        if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== q[0]) begin
          errors++; $display("FAIL rnd_beat c%0d: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                             c, m_tdata, m_tkeep, m_tuser, m_tlast, q[0].d, q[0].k, q[0].u, q[0].l);
        end
      end
      if (m_tvalid && m_tready && q.size() != 0) begin
        if (q[0].l) exp_pkt++;
        $display("random beat %0d data=%h last=%b", nout, q[0].d, q[0].l);
        nout++;
        void'(q.pop_front());
      end
      if (s_tvalid && s_tready) q.push_back(b);
    end
    check_counters("random");
  endtask

  task automatic test_async_reset();
    logic [TDW-1:0] d0, e0, e1;
    d0 = {$urandom, $urandom}; e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
    drive(1'b1, d0, '1, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, {$urandom, $urandom}, '1, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== d0) begin errors++; $display("FAIL ar_pre: got v=%b d=%h expected d=%h", m_tvalid, m_tdata, d0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL ar_async: got v=%b l=%b rdy=%b expected 0 0 0", m_tvalid, m_tlast, s_tready); end
    exp_pkt = 0; exp_trunc = 0;
    check_counters("async_reset");
    @(posedge clk); #1; rst_n = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
    // A port reset now must not emit a terminator, proving the FSM left mid-packet.
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar_idle1: got v=%b expected 0", m_tvalid); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar_idle2: got v=%b expected 0", m_tvalid); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, e0, '1, 10'h2A, 1'b0, 1'b1, 1'b1);
    drive(1'b1, e1, '1, 10'h15, 1'b1, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== e0 || m_tlast !== 1'b0) begin errors++; $display("FAIL ar_pkt0: got v=%b d=%h l=%b expected d=%h l=0", m_tvalid, m_tdata, m_tlast, e0); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== e1 || m_tlast !== 1'b1 || m_tuser !== 10'h15) begin errors++; $display("FAIL ar_pkt1: got v=%b d=%h l=%b expected d=%h l=1", m_tvalid, m_tdata, m_tlast, e1); end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar_tail: got v=%b expected 0", m_tvalid); end
    exp_pkt++;
    check_counters("async_after");
  endtask

`ifdef PG_PORT_TX_GATE_STATS_EN
  task automatic test_trunc_sat();
    force dut.trunc_cnt_reg = 16'hFFFE;
    @(posedge clk); #1;
    release dut.trunc_cnt_reg;
    exp_trunc = 65534;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, {$urandom, $urandom}, '1, '0, 1'b0, 1'b1, 1'b1);
      repeat (3) drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      repeat (2) drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
      exp_trunc = (exp_trunc < 65535) ? exp_trunc + 1 : 65535;
      exp_pkt++;
      check_counters("trunc_sat");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_trunc();
    test_trunc_stall();
    test_block_idle();
    test_random();
    test_async_reset();
`ifdef PG_PORT_TX_GATE_STATS_EN
    test_trunc_sat();
`endif
    $display("model totals: packets=%0d truncations=%0d", exp_pkt, exp_trunc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
